// File: rtl/park_pkg.sv
// Shared parking-system definitions: slot geometry, entry FSM encoding and
// the token cipher used by both the entry and exit paths.
package park_pkg;

  localparam int NUM_SLOTS = 8;
  localparam int SLOT_W    = 3;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SEARCH = 2'd1;
  localparam logic [1:0] ST_ISSUE  = 2'd2;

  function automatic logic [SLOT_W-1:0] rotl3(input logic [SLOT_W-1:0] x);
    return {x[1:0], x[2]};
  endfunction

  function automatic logic [SLOT_W-1:0] rotr3(input logic [SLOT_W-1:0] x);
    return {x[0], x[2:1]};
  endfunction

  // encrypt and decrypt are exact inverses for any fixed pattern
  function automatic logic [SLOT_W-1:0] encrypt(input logic [SLOT_W-1:0] slot,
                                                input logic [SLOT_W-1:0] pattern);
    return rotl3(slot ^ pattern);
  endfunction

  function automatic logic [SLOT_W-1:0] decrypt(input logic [SLOT_W-1:0] token,
                                                input logic [SLOT_W-1:0] pattern);
    return rotr3(token) ^ pattern;
  endfunction

endpackage

// File: rtl/enter_park_encrypt.sv
// Slot-number cipher for the entry side; the exit side applies decrypt()
// with the same pattern to recover the slot.
module enter_park_encrypt
  import park_pkg::*;
(
  input  logic [SLOT_W-1:0] slot,
  input  logic [SLOT_W-1:0] pattern,
  output logic [SLOT_W-1:0] token
);

  assign token = encrypt(slot, pattern);

endmodule

// File: rtl/enter_park.sv
// Entry-side parking controller: owns the occupancy map, allocates the lowest
// free slot and issues an encrypted token. Define ENTER_TIMEOUT_EN to release
// slots whose token is not acknowledged within TIMEOUT_CYCLES.
module enter_park
  import park_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enter,
  input  logic [SLOT_W-1:0]    pattern,
  output logic                 enter_ready,
  output logic [SLOT_W-1:0]    token,
  output logic                 token_valid,
  input  logic                 token_ack,
  output logic                 rejected,
  input  logic                 exit,
  input  logic [SLOT_W-1:0]    exit_number,
  output logic                 exit_error,
  output logic [NUM_SLOTS-1:0] park_location
);

  logic [1:0]           state_reg;
  logic [SLOT_W-1:0]    index_reg;
  logic [SLOT_W-1:0]    pattern_reg;
  logic [SLOT_W-1:0]    token_next;
  logic                 exit_hit;
  logic                 alloc;
  logic                 expire;
  logic [NUM_SLOTS-1:0] exit_mask;
  logic [NUM_SLOTS-1:0] alloc_mask;
  logic [NUM_SLOTS-1:0] expire_mask;

  enter_park_encrypt u_encrypt (
    .slot    (index_reg),
    .pattern (pattern_reg),
    .token   (token_next)
  );

  assign enter_ready = (state_reg == ST_IDLE);
  assign exit_hit    = exit && park_location[exit_number];
  assign alloc       = (state_reg == ST_SEARCH) && !park_location[index_reg];

  // An allocated bit was free and an exited bit was occupied, so the two
  // masks never collide and can be applied together.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_mask
      assign exit_mask[gi]  = exit_hit && (exit_number == SLOT_W'(gi));
      assign alloc_mask[gi] = alloc && (index_reg == SLOT_W'(gi));
    end
  endgenerate

`ifdef ENTER_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) < 4) ? 4 : $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0]  wait_cnt_reg;
  logic [SLOT_W-1:0] held_slot;

  // The pending slot is recovered from the held token rather than stored twice
  assign held_slot = decrypt(token, pattern_reg);
  assign expire    = (state_reg == ST_ISSUE) && !token_ack &&
                     (wait_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_expire
      assign expire_mask[gi] = expire && (held_slot == SLOT_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_reg <= '0;
    end else if (alloc) begin
      wait_cnt_reg <= '0;
    end else if (state_reg == ST_ISSUE) begin
      wait_cnt_reg <= wait_cnt_reg + 1'b1;
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign expire         = 1'b0;
  assign expire_mask    = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      index_reg     <= '0;
      pattern_reg   <= '0;
      token         <= '0;
      token_valid   <= 1'b0;
      rejected      <= 1'b0;
      exit_error    <= 1'b0;
      park_location <= '0;
    end else begin
      rejected      <= 1'b0;
      exit_error    <= exit && !park_location[exit_number];
      park_location <= (park_location | alloc_mask) & ~exit_mask & ~expire_mask;

      case (state_reg)
        ST_IDLE: begin
          // Full check deliberately uses the pre-exit map
          if (enter) begin
            if (&park_location) begin
              rejected <= 1'b1;
            end else begin
              pattern_reg <= pattern;
              index_reg   <= '0;
              state_reg   <= ST_SEARCH;
            end
          end
        end
        ST_SEARCH: begin
          if (alloc) begin
            token       <= token_next;
            token_valid <= 1'b1;
            state_reg   <= ST_ISSUE;
          end else begin
            index_reg <= index_reg + 1'b1;
          end
        end
        ST_ISSUE: begin
          if (token_ack || expire) begin
            token_valid <= 1'b0;
            state_reg   <= ST_IDLE;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_enter_park.sv
// Self-checking bench for enter_park: a slot-level reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_enter_park;

`ifdef ENTER_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif
  localparam int TO = TMO_EN ? 4 : 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enter = 1'b0;
  logic [2:0] pattern = 3'b000;
  logic       token_ack = 1'b0;
  logic       exit = 1'b0;
  logic [2:0] exit_number = 3'b000;
  logic       enter_ready;
  logic [2:0] token;
  logic       token_valid;
  logic       rejected;
  logic       exit_error;
  logic [7:0] park_location;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  enter_park #(.TIMEOUT_CYCLES(TO)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enter         (enter),
    .pattern       (pattern),
    .enter_ready   (enter_ready),
    .token         (token),
    .token_valid   (token_valid),
    .token_ack     (token_ack),
    .rejected      (rejected),
    .exit          (exit),
    .exit_number   (exit_number),
    .exit_error    (exit_error),
    .park_location (park_location)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit [7:0] m_map;
  int       m_phase;   // 0 waiting for a car, 1 scanning, 2 token pending
  int       m_scan;
  int       m_slot;
  int       m_wait;
  bit [2:0] m_key;
  bit [2:0] m_token;
  bit       m_valid;
  bit       m_rej;
  bit       m_err;

  function automatic bit [2:0] enc(input int slot, input bit [2:0] key);
    int x;
    x = slot ^ int'(key);
    return 3'(((x * 2) % 8) + (x / 4));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit [7:0] nmap;
    if (!rst_n) begin
      m_map = 8'h00; m_phase = 0; m_scan = 0; m_slot = 0; m_wait = 0;
      m_key = 3'b000; m_token = 3'b000; m_valid = 1'b0; m_rej = 1'b0; m_err = 1'b0;
    end else begin
      nmap  = m_map;
      m_rej = 1'b0;
      m_err = 1'b0;
      if (exit) begin
        if (m_map[exit_number]) nmap[exit_number] = 1'b0;
        else m_err = 1'b1;
      end
      if (m_phase == 0) begin
        if (enter) begin
          if (m_map == 8'hFF) m_rej = 1'b1;
          else begin m_key = pattern; m_scan = 0; m_phase = 1; end
        end
      end else if (m_phase == 1) begin
        if (!m_map[m_scan]) begin
          nmap[m_scan] = 1'b1;
          m_slot  = m_scan;
          m_token = enc(m_scan, m_key);
          m_valid = 1'b1;
          m_wait  = 0;
          m_phase = 2;
        end else begin
          m_scan++;
        end
      end else begin
        if (token_ack) begin
          m_valid = 1'b0; m_phase = 0;
        end else if (TMO_EN && m_wait == TO - 1) begin
          nmap[m_slot] = 1'b0; m_valid = 1'b0; m_phase = 0;
        end else begin
          m_wait++;
        end
      end
      m_map = nmap;
    end
  end

  always @(posedge clk) begin
    #1;
    chk("cyc_enter_ready", enter_ready, m_phase == 0);
    chk("cyc_token_valid", token_valid, m_valid);
    chk("cyc_rejected", rejected, m_rej);
    chk("cyc_exit_error", exit_error, m_err);
    chk("cyc_park_location", park_location, m_map);
    if (m_valid) chk("cyc_token", token, m_token);
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!token_valid && n < 12) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!token_valid) begin
      fails++;
      $display("FAIL %s: token_valid got 0 after %0d cycles, required 1", name, n);
    end
  endtask

  task automatic ack();
    token_ack = 1'b1;
    @(negedge clk);
    token_ack = 1'b0;
  endtask

  task automatic alloc(input logic [2:0] p);
    pattern = p;
    enter = 1'b1;
    @(negedge clk);
    enter = 1'b0;
    wait_valid("alloc_wait");
    ack();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_enter_ready", enter_ready, 1);
    chk("rst_token", token, 3'b000);
    chk("rst_token_valid", token_valid, 0);
    chk("rst_park_location", park_location, 8'h00);
    chk("rst_rejected", rejected, 0);
    chk("rst_exit_error", exit_error, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // empty lot, pattern 101 -> slot 0, token 011, valid after edge 1
    pattern = 3'b101; enter = 1'b1;
    @(negedge clk);
    enter = 1'b0;
    chk("t1_valid_edge0", token_valid, 0);
    @(negedge clk);
    chk("t1_valid_edge1", token_valid, 1);
    chk("t1_token", token, 3'b011);
    chk("t1_map", park_location, 8'h01);
    ack();
    chk("t1_ack_valid", token_valid, 0);
    chk("t1_ack_ready", enter_ready, 1);

    // map 0000_0111, pattern 000 -> slot 3 chosen at edge 4, token 110
    alloc(3'b000);
    alloc(3'b000);
    chk("t2_map_pre", park_location, 8'h07);
    pattern = 3'b000; enter = 1'b1;
    @(negedge clk);
    enter = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t2_still_searching", token_valid, 0);
    end
    @(negedge clk);
    chk("t2_valid", token_valid, 1);
    chk("t2_token", token, 3'b110);
    chk("t2_map", park_location, 8'h0F);
    ack();
    chk("t2_ack_valid", token_valid, 0);
    chk("t2_ack_ready", enter_ready, 1);

    // full lot: enter with simultaneous exit of slot 2 is rejected
    repeat (4) alloc(3'b011);
    chk("t3_map_full", park_location, 8'hFF);
    pattern = 3'b001; enter = 1'b1; exit = 1'b1; exit_number = 3'd2;
    @(negedge clk);
    enter = 1'b0; exit = 1'b0;
    chk("t3_rejected", rejected, 1);
    chk("t3_map", park_location, 8'hFB);
    chk("t3_no_token", token_valid, 0);
    chk("t3_ready", enter_ready, 1);
    @(negedge clk);
    chk("t3_rejected_pulse", rejected, 0);
    pattern = 3'b111; enter = 1'b1;
    @(negedge clk);
    enter = 1'b0;
    wait_valid("t3_wait");
    chk("t3_token_slot2", token, 3'b011);
    chk("t3_map_refill", park_location, 8'hFF);
    ack();

    // exit errors and exit coinciding with allocation
    exit = 1'b1; exit_number = 3'd5;
    @(negedge clk);
    exit = 1'b0;
    chk("t4_exit_ok_map", park_location, 8'hDF);
    chk("t4_exit_ok_err", exit_error, 0);
    exit = 1'b1; exit_number = 3'd5;
    @(negedge clk);
    exit = 1'b0;
    chk("t4_exit_err", exit_error, 1);
    chk("t4_exit_err_map", park_location, 8'hDF);
    @(negedge clk);
    chk("t4_exit_err_pulse", exit_error, 0);
    pattern = 3'b000; enter = 1'b1;
    @(negedge clk);
    enter = 1'b0;
    repeat (5) @(negedge clk);
    exit = 1'b1; exit_number = 3'd1;
    @(negedge clk);
    exit = 1'b0;
    chk("t4_alloc_valid", token_valid, 1);
    chk("t4_alloc_token", token, 3'b011);
    chk("t4_alloc_map", park_location, 8'hFD);
    ack();

    // token held with no ack; enter is ignored meanwhile
    pattern = 3'b000; enter = 1'b1;
    repeat (3) @(negedge clk);
    chk("t5_valid", token_valid, 1);
    chk("t5_token", token, 3'b010);
    chk("t5_map", park_location, 8'hFF);
    repeat (3) begin
      @(negedge clk);
      chk("t5_ignored_ready", enter_ready, 0);
      chk("t5_held_token", token, 3'b010);
    end
    enter = 1'b0;
    @(negedge clk);
    chk("t5_edge6_valid", token_valid, TMO_EN ? 0 : 1);
    chk("t5_edge6_map", park_location, TMO_EN ? 8'hFD : 8'hFF);
    if (token_valid) ack();

    // asynchronous reset in the middle of a scan
    exit = 1'b1; exit_number = 3'd7;
    @(negedge clk);
    exit = 1'b0;
    pattern = 3'b010; enter = 1'b1;
    @(negedge clk);
    enter = 1'b0;
    chk("t6_searching", enter_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_map", park_location, 8'h00);
    chk("t6_async_valid", token_valid, 0);
    chk("t6_async_ready", enter_ready, 1);
    chk("t6_async_token", token, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pattern = 3'b101; enter = 1'b1;
    @(negedge clk);
    enter = 1'b0;
    @(negedge clk);
    chk("t6_post_valid", token_valid, 1);
    chk("t6_post_token", token, 3'b011);
    chk("t6_post_map", park_location, 8'h01);
    ack();
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/enter_park.md
Name: enter_park

Overview:
- Entry-side controller of the parking system and the counterpart of the exit path.
- On a car arrival it scans the 8-slot occupancy map for the lowest free slot, marks it occupied, and issues an encrypted 3-bit token.
- The exit path decrypts that token with the same pattern to recover the slot number.
- This block also accepts exit notifications so it owns the occupancy map (park_location).

Parameters:
- TIMEOUT_CYCLES, 15, cycles a token may wait unacknowledged before the slot is released (used only with ENTER_TIMEOUT_EN).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- enter  input  1  car-arrival request; accepted when enter && enter_ready.
- pattern  input  3  encryption key; latched on enter acceptance.
- enter_ready  output  1  high only in IDLE.
- token  output  3  encrypted slot number; valid while token_valid.
- token_valid  output  1  token held until token_ack.
- token_ack  input  1  token consumed (gate display/ticket printer).
- rejected  output  1  one-cycle pulse: enter refused, lot full.
- exit  input  1  one-cycle car-exit strobe.
- exit_number  input  3  decrypted slot number accompanying exit.
- exit_error  output  1  one-cycle pulse: exit named an unoccupied slot.
- park_location  output  8  occupancy map, bit i = slot i occupied.

Behaviour:
- Reset (async, rst_n low): state IDLE, park_location = 8'h00, token = 3'b000, token_valid = 0, rejected = 0, exit_error = 0, scan index = 0, pattern register = 0.
- Encryption: token = rotl3(slot ^ pattern), where rotl3(x) = {x[1:0], x[2]}. Decryption (exit side) is slot = rotr3(token) ^ pattern.
- FSM states: IDLE, SEARCH, ISSUE.
- IDLE:
  - On enter with park_location == 8'hFF (registered value, pre-exit): pulse rejected next cycle; stay IDLE.
  - Otherwise: latch pattern, set index = 0, go to SEARCH.
- SEARCH:
  - Examine one slot per cycle, in ascending index order.
  - If park_location[index] == 0: set that bit, register token, assert token_valid, go to ISSUE.
  - Else: index += 1.
  - A free slot is guaranteed, because entry was refused if full and exits only free slots, so the scan never wraps.
- Latency: enter sampled at edge 0; slot k is chosen at edge 1+k; token_valid is high after edge 1+k. Best case is 2 cycles, worst case 9 cycles.
- ISSUE:
  - token and token_valid are held stable until token_ack is sampled high. The token_valid && token_ack edge clears token_valid and returns the FSM to IDLE.
  - token_ack outside ISSUE is ignored.
- enter is ignored while enter_ready = 0. There is no queuing; the requester must hold enter or retry.
- Exit:
  - Processed in every state.
  - If park_location[exit_number] == 1: clear that bit at the next edge.
  - Otherwise: pulse exit_error and leave the map unchanged.
- Simultaneous exit and SEARCH allocation: both updates apply in the same cycle.
  - The two always target different bits, because the allocated bit was free and the exited bit was occupied.
  - A slot freed behind the scan index is not revisited.
- Simultaneous enter and exit in IDLE: the full check uses the pre-exit map, so enter is rejected if the map was 8'hFF.
- Reset mid-operation: all state is lost, the map clears, and any pending token is dropped.

Optional Feature:
- Macro: ENTER_TIMEOUT_EN.
- Defined:
  - A 4-bit+ counter starts at entry to ISSUE.
  - If token_ack has not arrived after TIMEOUT_CYCLES cycles in ISSUE, the allocated slot bit is cleared, token_valid drops, and the FSM returns to IDLE.
  - token_ack on the same cycle as expiry wins: the slot is kept.
- Undefined: ISSUE waits indefinitely for token_ack, and TIMEOUT_CYCLES is unused.

Decomposition:
- Shared package park_pkg:
  - NUM_SLOTS = 8 and SLOT_W = 3.
  - State encoding constants for IDLE, SEARCH and ISSUE.
  - encrypt/decrypt functions (rotl3/rotr3 with XOR), so entry and exit stay inverse by construction.
- One natural sub-module: encrypt (slot, pattern -> token), the mirror of the exit-side decrypt.

Test Plan:
- Reset, pattern = 3'b101, enter on an empty lot -> slot 0 chosen, token = rotl3(000^101) = 3'b011, token_valid 2 cycles after enter, park_location = 8'h01.
- Map = 8'b0000_0111, pattern = 3'b000, enter -> slot 3 found after 4 SEARCH cycles, token = 3'b110, map = 8'h0F; token_ack -> token_valid low, enter_ready high next cycle.
- Map = 8'hFF, enter with a simultaneous exit of slot 2 -> rejected pulses, map becomes 8'hFB, no token issued; a later enter allocates slot 2.
- exit_number = 5 with bit 5 clear -> exit_error pulses for one cycle, map unchanged; an exit during SEARCH of an occupied slot clears its bit in the same cycle the new slot is set.
- token_valid held without ack, enter pulsed -> ignored (enter_ready = 0); with ENTER_TIMEOUT_EN and TIMEOUT_CYCLES = 4, no ack -> after 4 ISSUE cycles the slot bit clears and the FSM returns to IDLE.
- Assert rst_n low during SEARCH -> outputs return to reset values immediately (asynchronously), map = 8'h00.
